apb_master: RTL and testbench

APB4 requester that turns a simple valid/ready command stream into APB transfers on the shared peripheral bus feeding the RAM and UART slaves. It decodes the target slave from the top two address bits, drives a one-hot `PSEL[3:0]`, sequences SETUP/ACCESS, and returns read data and error status on a valid/ready response channel. A bounded wait counter terminates hung transfers with an error.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_master_if.sv | 49 ++++
 rtl/apb_wait_timer.sv | 26 ++
 rtl/apb_master.sv | 154 +++++++++++++++
 tb/tb_apb_master.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB requester: FSM state encoding and
// slave-select decoding.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int SLV_IDX_W = 2;

  localparam logic [SLV_IDX_W-1:0] RAM  = 2'd0;
  localparam logic [SLV_IDX_W-1:0] UART = 2'd1;

  function automatic logic [3:0] slv_onehot(input logic [SLV_IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response stream plus APB4 bus of the requester, bundled for port use.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [3:0]            cmd_strb;
  logic [2:0]            cmd_prot;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic [3:0]            PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [3:0]            PSTRB;
  logic [2:0]            PPROT;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter; expired once the count reaches limit.
module apb_wait_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  assign expired = (count >= limit);

  // Holding at the limit keeps the counter from wrapping during long stalls.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB4 requester: one outstanding command at a time, registered APB and
// response outputs, timeout-terminated ACCESS phase.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         PCLK,
  input  logic         PRESET,
  apb_master_if.master bus
);

  localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_e state, state_nxt;

  logic [3:0]            psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q,  pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
  logic [3:0]            pstrb_q,   pstrb_d;
  logic [2:0]            pprot_q,   pprot_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic accept;
  logic expired;

  // cmd_ready is registered, so the cycle right after reset refuses commands.
  assign accept = (state == IDLE) && cmd_ready_q && bus.cmd_valid;

  apb_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !bus.PREADY),
    .limit   (LIMIT),
    .expired (expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.PREADY || expired) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cmd_ready_d   = (state_nxt == IDLE);
    unique case (state)
      IDLE: begin
        if (accept) begin
          psel_d   = slv_onehot(bus.cmd_addr[ADDR_WIDTH-1 -: SLV_IDX_W]);
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          pstrb_d  = bus.cmd_write ? bus.cmd_strb : 4'b0000;
          pprot_d  = bus.cmd_prot;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        // PREADY wins over an expiring counter in the same cycle.
        if (bus.PREADY) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (expired) begin
          psel_d        = '0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end
      end
      RESP: if (bus.rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.PPROT       = pprot_q;
  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: scoreboarded responses, APB phase checks,
// timeout, backpressure and mid-transfer reset.
module tb_apb_master;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus();

  apb_master #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          lat;
    int          nacc;
  } rsp_t;

  rsp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_xfer(input string tag, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, input int waits,
                          input logic [31:0] prd, input logic serr, input int bp);
    rsp_t        e;
    rsp_t        got;
    int          w;
    int          k;
    logic [3:0]  psel_e;
    logic [31:0] r0;
    logic        e0, t0;
    w = 0;
    while (!bus.cmd_ready && w < 10) begin
      step();
      w++;
    end
    chk({tag, " cmd_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
    e.tmo   = (waits >= TO);
    e.rdata = (e.tmo || wr) ? 32'h0 : prd;
    e.err   = e.tmo | serr;
    e.lat   = e.tmo ? 2 + TO : 3 + waits;
    e.nacc  = e.tmo ? TO : waits + 1;
    sb.push_back(e);
    psel_e = 4'b0001 << addr[15:14];
    cyc = 0;
    step();
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = ~wdata;
    chk({tag, " setup PSEL"}, bus.PSEL, psel_e);
    chk({tag, " setup PENABLE"}, bus.PENABLE, 0);
    chk({tag, " setup PADDR"}, bus.PADDR, addr);
    chk({tag, " setup PWRITE"}, bus.PWRITE, wr);
    chk({tag, " setup PSTRB"}, bus.PSTRB, wr ? strb : 4'h0);
    chk({tag, " setup PPROT"}, bus.PPROT, prot);
    chk({tag, " setup cmd_ready"}, bus.cmd_ready, 0);
    if (wr) chk({tag, " setup PWDATA"}, bus.PWDATA, wdata);
    step();
    k = 0;
    for (int c = 0; c < 20 && !bus.rsp_valid; c++) begin
      chk({tag, " access PENABLE"}, bus.PENABLE, 1);
      chk({tag, " access PSEL"}, bus.PSEL, psel_e);
      chk({tag, " access PADDR"}, bus.PADDR, addr);
      if (wr) chk({tag, " access PWDATA"}, bus.PWDATA, wdata);
      bus.PREADY  = (k == waits);
      bus.PRDATA  = (k == waits) ? prd : ~prd;
      bus.PSLVERR = (k == waits) ? serr : 1'b1;
      k++;
      step();
    end
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 32'h0;
    chk({tag, " rsp_valid"}, bus.rsp_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 0, 1);
      return;
    end
    got = sb.pop_front();
    chk({tag, " latency"}, cyc, got.lat);
    chk({tag, " access cycles"}, k, got.nacc);
    chk({tag, " resp PSEL"}, bus.PSEL, 0);
    chk({tag, " resp PENABLE"}, bus.PENABLE, 0);
    chk({tag, " rsp_rdata"}, bus.rsp_rdata, got.rdata);
    chk({tag, " rsp_err"}, bus.rsp_err, got.err);
    chk({tag, " rsp_timeout"}, bus.rsp_timeout, got.tmo);
    r0 = bus.rsp_rdata;
    e0 = bus.rsp_err;
    t0 = bus.rsp_timeout;
    for (int b = 0; b < bp; b++) begin
      step();
      chk({tag, " bp rsp_valid"}, bus.rsp_valid, 1);
      chk({tag, " bp rsp_rdata"}, bus.rsp_rdata, r0);
      chk({tag, " bp rsp_err"}, {bus.rsp_err, bus.rsp_timeout}, {e0, t0});
      chk({tag, " bp cmd_ready"}, bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk({tag, " post rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, " post cmd_ready"}, bus.cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int saw;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    chk("reset PSEL", bus.PSEL, 0);
    chk("reset PENABLE", bus.PENABLE, 0);
    chk("reset cmd_ready", bus.cmd_ready, 0);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    rst = 1'b0;
    step();
    step();
    chk("idle cmd_ready", bus.cmd_ready, 1);

    run_xfer("zw_write", 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 32'hAAAA5555, 1'b0, 0);
    run_xfer("ws_read",  1'b0, 16'h4004, 32'h11111111, 4'hF, 3'b010, 3, 32'h12345678, 1'b0, 0);
    run_xfer("slverr",   1'b0, 16'h8008, 32'h0,        4'h0, 3'b001, 0, 32'h0BADF00D, 1'b1, 0);
    run_xfer("timeout",  1'b0, 16'hC000, 32'h0,        4'h0, 3'b000, 99, 32'h87654321, 1'b0, 0);
    run_xfer("bp_write", 1'b1, 16'h0020, 32'hA5A5F00F, 4'h3, 3'b100, 0, 32'h0,        1'b0, 5);
    run_xfer("b2b_read", 1'b0, 16'h4000, 32'h0,        4'h0, 3'b000, 1, 32'h13572468, 1'b0, 0);

    // Abort a write in the middle of its wait states.
    chk("abort cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 16'h8030;
    bus.cmd_wdata = 32'h55AA55AA;
    bus.cmd_strb  = 4'h3;
    bus.cmd_prot  = 3'b111;
    step();
    bus.cmd_valid = 1'b0;
    step();
    chk("abort in ACCESS", bus.PENABLE, 1);
    step();
    rst = 1'b1;
    step();
    chk("rst PSEL", bus.PSEL, 0);
    chk("rst PENABLE", bus.PENABLE, 0);
    chk("rst PWRITE", bus.PWRITE, 0);
    chk("rst PADDR", bus.PADDR, 0);
    chk("rst PWDATA", bus.PWDATA, 0);
    chk("rst PSTRB", bus.PSTRB, 0);
    chk("rst PPROT", bus.PPROT, 0);
    chk("rst cmd_ready", bus.cmd_ready, 0);
    chk("rst rsp_valid", bus.rsp_valid, 0);
    chk("rst rsp_rdata", bus.rsp_rdata, 0);
    chk("rst rsp_err", bus.rsp_err, 0);
    chk("rst rsp_timeout", bus.rsp_timeout, 0);
    rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.rsp_valid || bus.PENABLE) saw = 1;
    end
    chk("abort no response", saw, 0);

    run_xfer("post_rst", 1'b0, 16'h0044, 32'h0, 4'h0, 3'b000, 2, 32'hCAFEF00D, 1'b0, 0);
    chk("scoreboard drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
